// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter slice: FSM states, op encoding,
// and the saturating error-counter helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic OP_WRITE    = 1'b1;
  localparam logic OP_READ     = 1'b0;
  localparam int   ERR_CNT_MAX = 255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'(ERR_CNT_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side and RAM-side bus of the arbiter; master is the arbiter view,
// slave is the view of the requesters plus RAM that surround it.
interface ram_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wr_rd;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_error;

  logic                          en;
  logic                          wr_rd;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [DATA_WIDTH-1:0]         din;
  logic                          valid;
  logic [DATA_WIDTH-1:0]         dout;
  logic                          ready;
  logic                          error;

  modport master (
    input  req, req_wr_rd, req_addr, req_din, dout, ready, error,
    output gnt, rsp_valid, rsp_data, rsp_error, en, wr_rd, addr, din, valid
  );

  modport slave (
    output req, req_wr_rd, req_addr, req_din, dout, ready, error,
    input  gnt, rsp_valid, rsp_data, rsp_error, en, wr_rd, addr, din, valid
  );

endinterface

// File: rtl/ram_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping
// modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM among NUM_REQ
// requesters, with a per-command timeout so a silent RAM cannot hang the bus.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.master  bus,
  output logic           busy,
  output logic [7:0]     err_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;

  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_error_q, rsp_error_d;
  logic                  en_q, en_d;
  logic                  valid_q, valid_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  busy_q, busy_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [NUM_REQ-1:0]    win_oh;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_any;
  logic                  to_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .grant (win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Ready on the same edge as the final timeout count takes priority.
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT - 1)) && !bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_any) state_d = ISSUE;
      ISSUE:   if (bus.ready || to_hit) state_d = RESP;
      RESP:    state_d = win_any ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    en_d        = en_q;
    valid_d     = valid_q;
    wr_rd_d     = wr_rd_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rr_ptr_d    = rr_ptr_q;
    cur_d       = cur_q;
    to_cnt_d    = to_cnt_q;
    err_cnt_d   = err_cnt_q;
    busy_d      = (state_d == ISSUE);

    if (state_q == ISSUE) begin
      if (bus.ready) begin
        rsp_valid_d[cur_q] = 1'b1;
        rsp_data_d         = (wr_rd_q == OP_WRITE) ? '0 : bus.dout;
        rsp_error_d        = bus.error;
        en_d               = 1'b0;
        valid_d            = 1'b0;
        to_cnt_d           = '0;
        if (bus.error) err_cnt_d = sat_inc8(err_cnt_q);
      end else if (to_hit) begin
        rsp_valid_d[cur_q] = 1'b1;
        rsp_data_d         = '0;
        rsp_error_d        = 1'b1;
        en_d               = 1'b0;
        valid_d            = 1'b0;
        to_cnt_d           = '0;
        err_cnt_d          = sat_inc8(err_cnt_q);
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end else if (win_any) begin
      gnt_d    = win_oh;
      en_d     = 1'b1;
      valid_d  = 1'b1;
      wr_rd_d  = bus.req_wr_rd[win_idx];
      addr_d   = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      din_d    = bus.req_din[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      cur_d    = win_idx;
      rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
      to_cnt_d = '0;
    end
  end

  // Registered outputs and datapath; reset drops any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      en_q        <= 1'b0;
      valid_q     <= 1'b0;
      wr_rd_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rr_ptr_q    <= '0;
      cur_q       <= '0;
      to_cnt_q    <= '0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      en_q        <= en_d;
      valid_q     <= valid_d;
      wr_rd_q     <= wr_rd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_q       <= cur_d;
      to_cnt_q    <= to_cnt_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.en        = en_q;
  assign bus.valid     = valid_q;
  assign bus.wr_rd     = wr_rd_q;
  assign bus.addr      = addr_q;
  assign bus.din       = din_q;
  assign busy          = busy_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: reset, fairness, table vectors, reset mid-command,
// randomized commands against a transaction-level model, err_cnt saturation.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] err_cnt;

  ram_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  ram_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    bit          wr;
    logic [7:0]  a;
    logic [31:0] d;
    int          lat;
    bit          rerr;
    logic [31:0] dout;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_en;
  } vec_t;

  vec_t        tbl[7];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          mptr = 0;
  int          model_err = 0;
  bit          cmd_wr[NUM_REQ];
  logic [7:0]  cmd_addr[NUM_REQ];
  logic [31:0] cmd_din[NUM_REQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int i = 0; i < NUM_REQ; i++)
      if (m[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic drive_cmds();
    for (int j = 0; j < NUM_REQ; j++) begin
      bus.req_wr_rd[j]          = cmd_wr[j];
      bus.req_addr[j*AW +: AW]  = cmd_addr[j];
      bus.req_din[j*DW +: DW]   = cmd_din[j];
    end
  endtask

  task automatic clear_cmds();
    for (int j = 0; j < NUM_REQ; j++) begin
      cmd_wr[j] = 1'b0; cmd_addr[j] = '0; cmd_din[j] = '0;
    end
  endtask

  // One full command: present mask, expect winner k, answer after lat ISSUE cycles.
  task automatic run_cmd(input string tag, input logic [3:0] mask, input int k, input int lat,
                         input bit rerr, input logic [31:0] dv, input logic [31:0] exp_data,
                         input bit exp_err, input int exp_en);
    int cnt;
    bit got;
    logic [3:0] oh;
    oh = 4'(1 << k);
    drive_cmds();
    bus.req = mask;
    step();
    check({tag, ".gnt"}, 64'(bus.gnt), 64'(oh));
    check({tag, ".en_valid_busy"}, 64'({bus.en, bus.valid, busy}), 64'(3'b111));
    check({tag, ".wr_rd"}, 64'(bus.wr_rd), 64'(cmd_wr[k]));
    check({tag, ".addr"}, 64'(bus.addr), 64'(cmd_addr[k]));
    check({tag, ".din"}, 64'(bus.din), 64'(cmd_din[k]));
    bus.req = '0;
    mptr = (k + 1) % NUM_REQ;
    cnt = 0;
    got = 1'b0;
    for (int c = 1; c <= TIMEOUT + 4 && !got; c++) begin
      if (bus.en) cnt++;
      bus.ready = (c == lat);
      bus.error = (c == lat) ? rerr : 1'($urandom);
      bus.dout  = (c == lat) ? dv : $urandom;
      step();
      bus.ready = 1'b0;
      bus.error = 1'b0;
      if (c == 1) check({tag, ".gnt_pulse"}, 64'(bus.gnt), 64'(0));
      if (bus.rsp_valid != '0) begin
        got = 1'b1;
        check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(oh));
        check({tag, ".rsp_data"}, 64'(bus.rsp_data), 64'(exp_data));
        check({tag, ".rsp_error"}, 64'(bus.rsp_error), 64'(exp_err));
        check({tag, ".en_dropped"}, 64'({bus.en, bus.valid}), 64'(0));
      end
    end
    check({tag, ".rsp_seen"}, 64'(got), 64'(1));
    check({tag, ".en_cycles"}, 64'(cnt), 64'(exp_en));
    if (exp_err && model_err < 255) model_err++;
    check({tag, ".err_cnt"}, 64'(err_cnt), 64'(model_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  m;
    int          k, lat;
    bit          rerr, tmo;
    logic [31:0] dv;

    tbl[0] = '{0, 1'b0, 8'h10, 32'h0,        2,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2};
    tbl[1] = '{2, 1'b1, 8'h3F, 32'h12345678, 1,  1'b0, 32'hAAAAAAAA, 32'h0,        1'b0, 1};
    tbl[2] = '{1, 1'b0, 8'h22, 32'h0,        99, 1'b0, 32'h0,        32'h0,        1'b1, 16};
    tbl[3] = '{3, 1'b0, 8'h80, 32'h0,        16, 1'b0, 32'h00005555, 32'h00005555, 1'b0, 16};
    tbl[4] = '{1, 1'b0, 8'h01, 32'h0,        1,  1'b1, 32'h00000077, 32'h00000077, 1'b1, 1};
    tbl[5] = '{0, 1'b1, 8'hFF, 32'hCAFEF00D, 3,  1'b1, 32'h11111111, 32'h0,        1'b1, 3};
    tbl[6] = '{2, 1'b0, 8'h7E, 32'h0,        1,  1'b1, 32'h00000001, 32'h00000001, 1'b1, 1};

    bus.req = '0; bus.req_wr_rd = '0; bus.req_addr = '0; bus.req_din = '0;
    bus.dout = '0; bus.ready = 1'b0; bus.error = 1'b0;
    clear_cmds();

    // Reset state
    step();
    step();
    check("reset.outputs", 64'({bus.gnt, bus.rsp_valid, bus.rsp_error, bus.en, bus.valid,
                                bus.wr_rd, busy, err_cnt}), 64'(0));
    check("reset.data", 64'({bus.rsp_data, bus.addr}), 64'(0));
    rst = 1'b0;

    // Fairness: all requesting, RAM ready immediately
    for (int j = 0; j < NUM_REQ; j++) begin
      cmd_addr[j] = 8'(8'h40 + j); cmd_din[j] = 32'(j);
    end
    drive_cmds();
    bus.req   = 4'hF;
    bus.ready = 1'b1;
    bus.dout  = 32'hCAFE0000;
    for (int c = 1; c <= 10; c++) begin
      step();
      check($sformatf("fair.gnt%0d", c), 64'(bus.gnt),
            64'((c % 2 == 1) ? (1 << (((c - 1) / 2) % NUM_REQ)) : 0));
      check($sformatf("fair.rsp%0d", c), 64'(bus.rsp_valid),
            64'((c % 2 == 0) ? (1 << ((c / 2 - 1) % NUM_REQ)) : 0));
      if (c % 2 == 0) check($sformatf("fair.data%0d", c), 64'(bus.rsp_data), 64'(32'hCAFE0000));
      if (c == 9) bus.req = '0;
    end
    bus.ready = 1'b0;
    mptr = 1;
    step();
    step();
    check("fair.idle", 64'({busy, bus.en, bus.gnt}), 64'(0));

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      clear_cmds();
      cmd_wr[tbl[i].k]   = tbl[i].wr;
      cmd_addr[tbl[i].k] = tbl[i].a;
      cmd_din[tbl[i].k]  = tbl[i].d;
      run_cmd($sformatf("vec%0d", i), 4'(1 << tbl[i].k), tbl[i].k, tbl[i].lat, tbl[i].rerr,
              tbl[i].dout, tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_en);
    end
    check("table.err_cnt", 64'(err_cnt), 64'(4));

    // Reset during the second ISSUE cycle
    clear_cmds();
    cmd_addr[1] = 8'h55;
    drive_cmds();
    bus.req = 4'b0010;
    step();
    check("rst.gnt", 64'(bus.gnt), 64'(4'b0010));
    bus.req = '0;
    step();
    rst = 1'b1;
    #1;
    check("rst.async_outputs", 64'({bus.gnt, bus.rsp_valid, bus.rsp_error, bus.en, bus.valid,
                                     bus.wr_rd, busy, err_cnt}), 64'(0));
    check("rst.async_data", 64'({bus.rsp_data, bus.addr}), 64'(0));
    bus.ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst.no_rsp", 64'({bus.rsp_valid, bus.en}), 64'(0));
    end
    bus.ready = 1'b0;
    rst = 1'b0;
    model_err = 0;
    mptr = 0;
    step();
    check("rst.no_rsp_after", 64'(bus.rsp_valid), 64'(0));
    clear_cmds();
    cmd_addr[0] = 8'hA0; cmd_addr[3] = 8'hA3; cmd_din[3] = 32'h33;
    run_cmd("rst.ptr0", 4'b1001, 0, 1, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1);
    run_cmd("rst.k3", 4'b1000, 3, 1, 1'b0, 32'h00C0FFEE, 32'h00C0FFEE, 1'b0, 1);

    // Randomized commands against the transaction model
    for (int i = 0; i < 150; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        cmd_wr[j] = 1'($urandom); cmd_addr[j] = 8'($urandom); cmd_din[j] = $urandom;
      end
      m    = 4'($urandom_range(1, 15));
      k    = rr_pick(m, mptr);
      lat  = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                         : $urandom_range(1, 4);
      rerr = ($urandom_range(0, 4) == 0);
      dv   = $urandom;
      tmo  = (lat > TIMEOUT);
      run_cmd($sformatf("rnd%0d", i), m, k, lat, rerr, dv,
              (tmo || cmd_wr[k]) ? 32'h0 : dv, tmo ? 1'b1 : rerr, tmo ? TIMEOUT : lat);
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    // err_cnt saturation
    for (int j = 0; j < NUM_REQ; j++) cmd_wr[j] = OP_WRITE;
    for (int i = 0; i < 260; i++) begin
      m = 4'($urandom_range(1, 15));
      k = rr_pick(m, mptr);
      run_cmd("sat", m, k, 1, 1'b1, $urandom, 32'h0, 1'b1, 1);
    end
    check("sat.err_cnt", 64'(err_cnt), 64'(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
